// File: rtl/fmul_result_buffer.sv
// Registered FIFO stage between the FP multiplier and writeback, with optional sticky exception flags.
// Define FMUL_RESULT_BUFFER_FLAGS_EN to build the sticky flag_of/flag_uf registers.
module fmul_result_buffer #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_d,
    input  logic                       in_overflow,
    input  logic                       in_underflow,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_d,
    output logic                       out_overflow,
    output logic                       out_underflow,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       flush,
    input  logic                       flag_clr,
    output logic                       flag_of,
    output logic                       flag_uf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 32 + 2 + TAG_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, wr_en;
    logic [ENT_W-1:0] head;

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~flush;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is intentionally not reset; head fields are meaningless while out_valid=0.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {in_d, in_overflow, in_underflow, in_tag};
    end

    assign head          = mem_q[rd_ptr_q];
    assign out_d         = head[ENT_W-1 -: 32];
    assign out_overflow  = head[TAG_W+1];
    assign out_underflow = head[TAG_W];
    assign out_tag       = head[TAG_W-1:0];

`ifdef FMUL_RESULT_BUFFER_FLAGS_EN
    logic flag_of_q, flag_of_d;
    logic flag_uf_q, flag_uf_d;

    // A flagged accepted push beats a same-cycle clear.
    always_comb begin
        flag_of_d = flag_clr ? 1'b0 : flag_of_q;
        flag_uf_d = flag_clr ? 1'b0 : flag_uf_q;
        if (wr_en && in_overflow)  flag_of_d = 1'b1;
        if (wr_en && in_underflow) flag_uf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flag_of_q <= 1'b0;
            flag_uf_q <= 1'b0;
        end else begin
            flag_of_q <= flag_of_d;
            flag_uf_q <= flag_uf_d;
        end
    end

    assign flag_of = flag_of_q;
    assign flag_uf = flag_uf_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign flag_of         = 1'b0;
    assign flag_uf         = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_result_buffer.sv
// Self-checking bench for fmul_result_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_fmul_result_buffer;

    localparam int DEPTH = 2;
    localparam int TAG_W = 6;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready, in_overflow, in_underflow;
    logic [31:0]      in_d, out_d;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             out_valid, out_ready, out_overflow, out_underflow;
    logic [CNT_W-1:0] count;
    logic             flush, flag_clr, flag_of, flag_uf;

    typedef struct packed {
        logic [31:0]      d;
        logic             ov;
        logic             uf;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    logic m_of, m_uf;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fmul_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
        .in_overflow(in_overflow), .in_underflow(in_underflow), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .out_tag(out_tag),
        .count(count), .flush(flush), .flag_clr(flag_clr),
        .flag_of(flag_of), .flag_uf(flag_uf)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ov, input logic uf,
                         input logic [TAG_W-1:0] tag, input logic ordy, input logic fl, input logic clr);
        in_valid = v; in_d = d; in_overflow = ov; in_underflow = uf; in_tag = tag;
        out_ready = ordy; flush = fl; flag_clr = clr;
    endtask

    task automatic check_outputs();
        check("count", 64'(count), 64'(q.size()));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        check("flag_of", 64'(flag_of), 64'(m_of));
        check("flag_uf", 64'(flag_uf), 64'(m_uf));
        if (q.size() != 0) begin
            check("out_d", 64'(out_d), 64'(q[0].d));
            check("out_tag", 64'(out_tag), 64'(q[0].tag));
            check("out_overflow", 64'(out_overflow), 64'(q[0].ov));
            check("out_underflow", 64'(out_underflow), 64'(q[0].uf));
        end
    endtask

    // Called one time unit after a rising edge with inputs already applied; ends the same way next cycle.
    task automatic step();
        logic p, r;
        ent_t e;
        #2;
        check_outputs();
        p = in_valid && (q.size() < DEPTH);
        r = out_ready && (q.size() != 0);
        e = '{d: in_d, ov: in_overflow, uf: in_underflow, tag: in_tag};
        if (flush) begin
            q.delete();
        end else begin
            if (r) void'(q.pop_front());
            if (p) q.push_back(e);
        end
`ifdef FMUL_RESULT_BUFFER_FLAGS_EN
        if (flag_clr) begin m_of = 1'b0; m_uf = 1'b0; end
        if (p && !flush && in_overflow)  m_of = 1'b1;
        if (p && !flush && in_underflow) m_uf = 1'b1;
`endif
        @(posedge clk); #1;
    endtask

    task automatic reset_mid();
        #2;
        rstn = 1'b0;
        #1;
        q.delete(); m_of = 1'b0; m_uf = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_flag_of", 64'(flag_of), 64'd0);
        check("rst_flag_uf", 64'(flag_uf), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        m_of = 1'b0; m_uf = 1'b0;
        rstn = 1'b0;
        drive(0, 32'h0, 0, 0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        step();

        // Reset mid-stream with two entries held.
        drive(1, 32'h3F800000, 1, 1, 6'd11, 0, 0, 0); step();
        drive(1, 32'h40000000, 0, 0, 6'd12, 0, 0, 0); step();
        drive(0, 32'h0, 0, 0, '0, 0, 0, 0);
        check("pre_rst_count", 64'(count), 64'd2);
        reset_mid();

        // Single push held for several cycles, then consumed.
        drive(1, 32'h40400000, 0, 0, 6'd5, 0, 0, 0); step();
        drive(0, 32'h0, 0, 0, '0, 0, 0, 0);
        check("single_d", 64'(out_d), 64'h40400000);
        check("single_tag", 64'(out_tag), 64'd5);
        repeat (3) step();
        drive(0, 32'h0, 0, 0, '0, 1, 0, 0); step();
        check("single_drained", 64'(out_valid), 64'd0);

        // Fill to full, attempt a third push, drain in order.
        drive(1, 32'h00000001, 0, 0, 6'd1, 0, 0, 0); step();
        drive(1, 32'h00000002, 0, 0, 6'd2, 0, 0, 0); step();
        drive(1, 32'h00000003, 0, 0, 6'd3, 0, 0, 0); step();
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(0, 32'h0, 0, 0, '0, 1, 0, 0);
        check("drain_first", 64'(out_tag), 64'd1);
        step();
        check("drain_second", 64'(out_tag), 64'd2);
        step(); step();

        // Simultaneous push and pop with one entry.
        drive(1, 32'h11111111, 0, 0, 6'd7, 0, 0, 0); step();
        drive(1, 32'h22222222, 0, 0, 6'd8, 1, 0, 0); step();
        drive(0, 32'h0, 0, 0, '0, 0, 0, 0);
        check("pp_count", 64'(count), 64'd1);
        check("pp_tag", 64'(out_tag), 64'd8);
        drive(0, 32'h0, 0, 0, '0, 1, 0, 0); step();

        // Sticky flags.
        drive(1, 32'h7F800000, 1, 0, 6'd20, 1, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h3F800000 + 32'(i), 0, 0, 6'(21 + i), 1, 0, 0); step();
        end
        drive(0, 32'h0, 0, 0, '0, 1, 0, 1); step();
        drive(1, 32'h00000000, 0, 1, 6'd30, 1, 0, 1); step();
        drive(0, 32'h0, 0, 0, '0, 1, 0, 0); step();
        step();

        // Flush with a full buffer and a push attempt, then with one entry and an accepted push.
        drive(1, 32'hAAAA0000, 0, 0, 6'd40, 0, 0, 0); step();
        drive(1, 32'hBBBB0000, 0, 0, 6'd41, 0, 0, 0); step();
        drive(1, 32'hCCCC0000, 0, 0, 6'd42, 0, 1, 0); step();
        drive(0, 32'h0, 0, 0, '0, 0, 0, 0);
        check("flush_valid", 64'(out_valid), 64'd0);
        step();
        drive(1, 32'hDDDD0000, 0, 0, 6'd43, 0, 0, 0); step();
        drive(1, 32'hEEEE0000, 0, 0, 6'd44, 1, 1, 0); step();
        drive(0, 32'h0, 0, 0, '0, 0, 0, 0);
        check("flush2_count", 64'(count), 64'd0);
        step();
        drive(1, 32'h12345678, 0, 0, 6'd45, 0, 0, 0); step();
        drive(0, 32'h0, 0, 0, '0, 1, 0, 0);
        check("after_flush_tag", 64'(out_tag), 64'd45);
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic fl;
            fl = ($urandom_range(0, 15) == 0);
            drive(($urandom_range(0, 3) != 0), $urandom(),
                  fl ? 1'b0 : ($urandom_range(0, 7) == 0),
                  fl ? 1'b0 : ($urandom_range(0, 7) == 0),
                  TAG_W'($urandom()), ($urandom_range(0, 2) != 0), fl,
                  ($urandom_range(0, 7) == 0));
            step();
        end

        drive(1, 32'h1, 0, 0, 6'd1, 0, 0, 0); step(); step();
        drive(0, 32'h0, 0, 0, '0, 0, 0, 0);
        reset_mid();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
